// File: rtl/spin_phase_reader.sv
// Samples asynchronous oscillator phases against a reference over a fixed window
// and serves majority-decided spins and mismatch counts over a read handshake.
module spin_phase_reader #(
  parameter int unsigned N           = 8,
  parameter int unsigned WINDOW_BITS = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         axi_rstn,
  input  logic         ising_rstn,
  input  logic [N-1:0] phase_in,
  input  logic         ref_in,
  input  logic         start,
  output logic         busy,
  output logic         done,
  input  logic         arvalid,
  output logic         arready,
  input  logic [7:0]   araddr,
  output logic         rvalid,
  input  logic         rready,
  output logic [31:0]  rdata
);

  localparam int unsigned CW = WINDOW_BITS + 1;
  localparam int unsigned SW = $clog2(SYNC_STAGES);
  localparam int unsigned TW = ((WINDOW_BITS > SW) ? WINDOW_BITS : SW) + 1;
  localparam logic [CW-1:0] HALF = CW'(2 ** (WINDOW_BITS - 1));

  typedef enum logic [2:0] {IDLE, SETTLE, SAMPLE, DECIDE, DONE} state_t;

  state_t                 state, next_state;
  logic [TW-1:0]          timer;
  logic [SYNC_STAGES-1:0] phase_sync [N];
  logic [SYNC_STAGES-1:0] ref_sync;
  logic [N-1:0]           mismatch;
  logic [CW-1:0]          cnt [N];
  logic [CW-1:0]          res_cnt [N];
  logic [N-1:0]           res_spin;
  logic                   aborted;
  logic                   accept;
  logic                   abort;
  logic [31:0]            rd_word;

  // MSB of each shift register is the oldest, fully synchronized sample.
  always_ff @(posedge clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      for (int unsigned i = 0; i < N; i++) phase_sync[i] <= '0;
      ref_sync <= '0;
    end else begin
      for (int unsigned i = 0; i < N; i++)
        phase_sync[i] <= {phase_sync[i][SYNC_STAGES-2:0], phase_in[i]};
      ref_sync <= {ref_sync[SYNC_STAGES-2:0], ref_in};
    end
  end

  always_comb begin
    mismatch = '0;
    for (int unsigned i = 0; i < N; i++)
      mismatch[i] = phase_sync[i][SYNC_STAGES-1] ^ ref_sync[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or negedge axi_rstn) begin
    if (!axi_rstn) state <= IDLE;
    else           state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start && ising_rstn) next_state = SETTLE;
      SETTLE:  if (!ising_rstn) next_state = IDLE;
               else if (timer == '0) next_state = SAMPLE;
      SAMPLE:  if (!ising_rstn) next_state = IDLE;
               else if (timer == '0) next_state = DECIDE;
      DECIDE:  next_state = ising_rstn ? DONE : IDLE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy   = (state == SETTLE) || (state == SAMPLE) || (state == DECIDE);
    accept = (state == IDLE) && start && ising_rstn;
    abort  = busy && !ising_rstn;
  end

  // Down-counter reloaded at each phase boundary; reaching zero ends the phase.
  always_ff @(posedge clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      timer <= '0;
    end else if (accept) begin
      timer <= TW'(SYNC_STAGES - 1);
    end else if (state == SETTLE && timer == '0) begin
      timer <= TW'(2 ** WINDOW_BITS - 1);
    end else if ((state == SETTLE || state == SAMPLE) && timer != '0) begin
      timer <= timer - TW'(1);
    end
  end

  always_ff @(posedge clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      for (int unsigned i = 0; i < N; i++) cnt[i] <= '0;
    end else if (accept) begin
      for (int unsigned i = 0; i < N; i++) cnt[i] <= '0;
    end else if (state == SAMPLE) begin
      for (int unsigned i = 0; i < N; i++) cnt[i] <= cnt[i] + CW'(mismatch[i]);
    end
  end

  always_ff @(posedge clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      for (int unsigned i = 0; i < N; i++) res_cnt[i] <= '0;
      res_spin <= '0;
    end else if (state == DECIDE && ising_rstn) begin
      for (int unsigned i = 0; i < N; i++) begin
        res_cnt[i]  <= cnt[i];
        res_spin[i] <= (cnt[i] > HALF);
      end
    end
  end

  always_ff @(posedge clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      done    <= 1'b0;
      aborted <= 1'b0;
    end else if (accept) begin
      done    <= 1'b0;
      aborted <= 1'b0;
    end else begin
      if (state == DONE) done <= 1'b1;
      if (abort)         aborted <= 1'b1;
    end
  end

  always_comb begin
    rd_word = '0;
    if (araddr == 8'd0) begin
      rd_word = {29'b0, aborted, done, busy};
    end else if (araddr == 8'd1) begin
      rd_word = 32'(res_spin);
    end else begin
      for (int unsigned i = 0; i < N; i++)
        if (araddr == 8'(i + 2)) rd_word = 32'(res_cnt[i]);
    end
  end

  assign arready = !rvalid;

  always_ff @(posedge clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      rvalid <= 1'b0;
      rdata  <= '0;
    end else if (arvalid && arready) begin
      rvalid <= 1'b1;
      rdata  <= rd_word;
    end else if (rvalid && rready) begin
      rvalid <= 1'b0;
    end
  end

endmodule
